// File: rtl/layer_sequencer.sv
// ----------------------------------------------------------------------------
// layer_sequencer
//   Controller for one fully-connected layer of numNeuron neurons that share a
//   weight/bias load bus and a broadcast input bus.
//
//   LOAD   : host words stream in; each neuron takes numWeight weights and then
//            one bias. Weights go out on weight_value/weight_valid, tagged by
//            cfg_neuron_num. Biases go out on bias_value with a one-hot
//            bias_valid strobe.
//   STREAM : numWeight inference inputs are broadcast on neuron_in.
//   WAIT   : waits until every neuron has pulsed outvalid once.
//   DRAIN  : captured results leave in neuron order on a valid/ready stream.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   load_start, infer_start  single-cycle start pulses, honoured only in IDLE
//   ld_data/ld_valid/ld_ready        host weight/bias stream
//   in_data/in_valid/in_ready        inference input stream
//   cfg_layer_num, cfg_neuron_num    neuron configuration tags
//   weight_value/weight_valid        broadcast weight strobe
//   bias_value/bias_valid            broadcast bias, one-hot per neuron
//   neuron_in/neuron_in_valid        broadcast inference input
//   neuron_out/neuron_outvalid       per-neuron results (packed slices)
//   res_data/res_idx/res_valid/res_ready/res_last  result stream
//   loaded, busy, err                status
//
// Optional feature
//   LAYER_SEQ_WDOG_EN : a watchdog bounds the time spent in WAIT to WDOG_CYCLES.
//                       On expiry err is set (sticky) and the results are
//                       drained anyway. Neurons that never answered read as 0.
//                       When the macro is undefined err is tied to 0.
// ----------------------------------------------------------------------------
module layer_sequencer #(
    parameter int layerNo     = 1,
    parameter int numNeuron   = 40,
    parameter int numWeight   = 128,
    parameter int dataWidth   = 16,
    parameter int outWidth    = 8,
    parameter int WDOG_CYCLES = 1024,
    localparam int IDXW = (numNeuron > 1) ? $clog2(numNeuron) : 1,
    localparam int CFGW = 2*dataWidth+1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start,
    input  logic                          infer_start,
    input  logic [dataWidth-1:0]          ld_data,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [dataWidth-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [CFGW-1:0]               cfg_layer_num,
    output logic [CFGW-1:0]               cfg_neuron_num,
    output logic [dataWidth-1:0]          weight_value,
    output logic                          weight_valid,
    output logic [dataWidth-1:0]          bias_value,
    output logic [numNeuron-1:0]          bias_valid,
    output logic [dataWidth-1:0]          neuron_in,
    output logic                          neuron_in_valid,
    input  logic [numNeuron*outWidth-1:0] neuron_out,
    input  logic [numNeuron-1:0]          neuron_outvalid,
    output logic [outWidth-1:0]           res_data,
    output logic [IDXW-1:0]               res_idx,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic                          res_last,
    output logic                          loaded,
    output logic                          busy,
    output logic                          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_WAIT,
        S_DRAIN
    } state_t;

    // w_cnt runs 0..numWeight: values below numWeight are weight slots and
    // numWeight itself is the bias slot of the current neuron.
    localparam int              WCW    = $clog2(numWeight+1);
    localparam logic [WCW-1:0]  W_BIAS = WCW'(numWeight);
    localparam logic [WCW-1:0]  I_LAST = WCW'(numWeight-1);
    localparam logic [IDXW-1:0] N_LAST = IDXW'(numNeuron-1);

    state_t                              state;
    logic [WCW-1:0]                      w_cnt;
    logic [WCW-1:0]                      i_cnt;
    logic [IDXW-1:0]                     n_cnt;

    logic [numNeuron-1:0]                cap_flag;
    logic [numNeuron-1:0][outWidth-1:0]  cap_mem;

    logic ld_fire, in_fire, res_fire;
    logic stream_go, cap_en, cap_clr, all_set;

    assign ld_ready  = (state == S_LOAD);
    assign in_ready  = (state == S_STREAM);
    assign busy      = (state != S_IDLE);
    assign ld_fire   = ld_valid & ld_ready;
    assign in_fire   = in_valid & in_ready;
    assign res_fire  = res_valid & res_ready;

    // load_start has priority over infer_start in IDLE
    assign stream_go = (state == S_IDLE) & ~load_start & infer_start & loaded;
    assign cap_en    = (state == S_STREAM) | (state == S_WAIT);
    // Flags clear on STREAM entry and again on the final input, so only
    // answers to the current inference count. A pulse in the clearing cycle
    // still wins (see the lane logic).
    assign cap_clr   = stream_go | (in_fire & (i_cnt == I_LAST));
    // Include pulses arriving this cycle so WAIT can leave without an extra cycle.
    assign all_set   = &(cap_flag | neuron_outvalid);

    assign cfg_layer_num = CFGW'(layerNo);
    assign res_data      = res_valid ? cap_mem[res_idx] : '0;

    // ---------------------------------------------------------------------
    // Per-neuron capture lanes
    // ---------------------------------------------------------------------
    for (genvar g = 0; g < numNeuron; g++) begin : g_lane
        logic                flag_q;
        logic [outWidth-1:0] mem_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                flag_q <= 1'b0;
                mem_q  <= '0;
            end else if (cap_en && neuron_outvalid[g]) begin
                flag_q <= 1'b1;
                mem_q  <= neuron_out[g*outWidth +: outWidth];
            end else if (cap_clr) begin
                flag_q <= 1'b0;
                mem_q  <= '0;
            end
        end

        assign cap_flag[g] = flag_q;
        assign cap_mem[g]  = mem_q;
    end

`ifdef LAYER_SEQ_WDOG_EN
    localparam int             WDW     = $clog2(WDOG_CYCLES+1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(WDOG_CYCLES-1);
    logic [WDW-1:0] wdog_cnt;
`else
    assign err = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            w_cnt           <= '0;
            n_cnt           <= '0;
            i_cnt           <= '0;
            weight_value    <= '0;
            weight_valid    <= 1'b0;
            cfg_neuron_num  <= '0;
            bias_value      <= '0;
            bias_valid      <= '0;
            neuron_in       <= '0;
            neuron_in_valid <= 1'b0;
            res_valid       <= 1'b0;
            res_idx         <= '0;
            res_last        <= 1'b0;
            loaded          <= 1'b0;
`ifdef LAYER_SEQ_WDOG_EN
            wdog_cnt        <= '0;
            err             <= 1'b0;
`endif
        end else begin
            // strobes are single-cycle
            weight_valid    <= 1'b0;
            bias_valid      <= '0;
            neuron_in_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state <= S_LOAD;
                        w_cnt <= '0;
                        n_cnt <= '0;
                    end else if (stream_go) begin
                        state <= S_STREAM;
                        i_cnt <= '0;
                    end
                end

                S_LOAD: begin
                    if (ld_fire) begin
                        if (w_cnt != W_BIAS) begin
                            weight_value   <= ld_data;
                            weight_valid   <= 1'b1;
                            cfg_neuron_num <= CFGW'(n_cnt);
                            w_cnt          <= w_cnt + 1'b1;
                        end else begin
                            bias_value <= ld_data;
                            bias_valid <= numNeuron'(1) << n_cnt;
                            w_cnt      <= '0;
                            n_cnt      <= n_cnt + 1'b1;
                            if (n_cnt == N_LAST) begin
                                loaded <= 1'b1;
                                state  <= S_IDLE;
                            end
                        end
                    end
                end

                S_STREAM: begin
                    if (in_fire) begin
                        neuron_in       <= in_data;
                        neuron_in_valid <= 1'b1;
                        i_cnt           <= i_cnt + 1'b1;
                        if (i_cnt == I_LAST) begin
                            state <= S_WAIT;
`ifdef LAYER_SEQ_WDOG_EN
                            wdog_cnt <= '0;
`endif
                        end
                    end
                end

                S_WAIT: begin
                    if (all_set) begin
                        state     <= S_DRAIN;
                        res_valid <= 1'b1;
                        res_idx   <= '0;
                        res_last  <= (N_LAST == '0);
`ifdef LAYER_SEQ_WDOG_EN
                    end else if (wdog_cnt == WD_LAST) begin
                        // give up on the silent neurons; their slots stay 0
                        err       <= 1'b1;
                        state     <= S_DRAIN;
                        res_valid <= 1'b1;
                        res_idx   <= '0;
                        res_last  <= (N_LAST == '0);
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
`endif
                    end
                end

                S_DRAIN: begin
                    if (res_fire) begin
                        if (res_last) begin
                            res_valid <= 1'b0;
                            res_last  <= 1'b0;
                            res_idx   <= '0;
                            state     <= S_IDLE;
                        end else begin
                            res_idx  <= res_idx + 1'b1;
                            res_last <= ((res_idx + 1'b1) == N_LAST);
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
